// File: rtl/branch_stats_if.sv
// Wishbone register-window bundle for branch_stats.
interface branch_stats_if;
  logic [1:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/branch_stats.sv
// Branch statistics: saturating total/taken/mispredict counters, a
// freezable display copy, and a small Wishbone register window.
module branch_stats #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_br_valid,
  input  logic             i_br_taken,
  input  logic             i_br_mispred,
  input  logic             i_clear,
  input  logic             i_freeze,
  branch_stats_if.slave    wb,
  output logic [WIDTH-1:0] o_branches,
  output logic [WIDTH-1:0] o_branches_taken,
  output logic             o_overflow
);

  typedef enum logic [1:0] {RUN, HOLD, CLR} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tot, tkn, mis;
  logic             ctrl_frz;
  logic             frz;
  logic             wb_acc, wb_wr3, clr_req;
  logic             cnt_en, inc_tot, inc_tkn, inc_mis, sat_hit;
  logic             disp_load;
  logic [31:0]      rd_data;
  logic             unused_dat;

  assign unused_dat = ^wb.i_wb_dat[31:2];

  // Access qualification, clear request and increment enables.
  always_comb begin
    wb_acc    = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
    wb_wr3    = wb_acc & wb.i_wb_we & (wb.i_wb_adr == 2'd3);
    clr_req   = i_clear | (wb_wr3 & wb.i_wb_dat[0]);
    frz       = i_freeze | ctrl_frz;
    cnt_en    = ~clr_req & (state != CLR);
    inc_tot   = cnt_en & i_br_valid;
    inc_tkn   = cnt_en & i_br_valid & i_br_taken;
    inc_mis   = cnt_en & i_br_valid & i_br_mispred;
    sat_hit   = (inc_tot & (tot == CNT_MAX)) |
                (inc_tkn & (tkn == CNT_MAX)) |
                (inc_mis & (mis == CNT_MAX));
    // Displays also load on the HOLD->RUN edge so an unfreeze shows the
    // live count one cycle later instead of two.
    disp_load = (state == RUN) | ((state == HOLD) & ~frz);
  end

  // Next-state logic; clear wins over everything else.
  always_comb begin
    state_nxt = state;
    if (clr_req) begin
      state_nxt = CLR;
    end else begin
      unique case (state)
        RUN:     state_nxt = frz ? HOLD : RUN;
        HOLD:    state_nxt = frz ? HOLD : RUN;
        CLR:     state_nxt = frz ? HOLD : RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  // Live counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tot <= '0;
      tkn <= '0;
      mis <= '0;
    end else if (clr_req) begin
      tot <= '0;
      tkn <= '0;
      mis <= '0;
    end else begin
      if (inc_tot && tot != CNT_MAX) tot <= tot + WIDTH'(1);
      if (inc_tkn && tkn != CNT_MAX) tkn <= tkn + WIDTH'(1);
      if (inc_mis && mis != CNT_MAX) mis <= mis + WIDTH'(1);
    end
  end

  // Display copies and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_branches       <= '0;
      o_branches_taken <= '0;
      o_overflow       <= 1'b0;
    end else if (clr_req) begin
      o_branches       <= '0;
      o_branches_taken <= '0;
      o_overflow       <= 1'b0;
    end else begin
      if (disp_load) begin
        o_branches       <= tot;
        o_branches_taken <= tkn;
      end
      if (sat_hit) o_overflow <= 1'b1;
    end
  end

  // Freeze control bit; a write carrying a clear leaves freeze untouched
  // so a frozen block can be cleared and stay frozen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            ctrl_frz <= 1'b0;
    else if (wb_wr3 && !wb.i_wb_dat[0])   ctrl_frz <= wb.i_wb_dat[1];
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_data = '0;
    unique case (wb.i_wb_adr)
      2'd0:    rd_data[WIDTH-1:0] = tot;
      2'd1:    rd_data[WIDTH-1:0] = tkn;
      2'd2:    rd_data[WIDTH-1:0] = mis;
      default: rd_data[2:0] = {state == HOLD, ctrl_frz, o_overflow};
    endcase
  end

  // Single-cycle ack with registered read data, zero outside the ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_rdt <= '0;
    end else begin
      wb.o_wb_ack <= wb_acc;
      wb.o_wb_rdt <= wb_acc ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_branch_stats.sv
// Directed self-checking bench for branch_stats (32-bit and 8-bit builds).
module tb_branch_stats;

  logic        clk;
  logic        rstn;
  logic        i_br_valid, i_br_taken, i_br_mispred, i_clear, i_freeze;
  logic [31:0] o_branches, o_branches_taken;
  logic        o_overflow;

  logic        v8, clr8;
  logic [7:0]  o_branches8, o_branches_taken8;
  logic        o_overflow8;

  int unsigned nchk;
  int unsigned nerr;
  logic [31:0] rd;

  branch_stats_if wb ();
  branch_stats_if wb8 ();

  branch_stats #(.WIDTH(32)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_br_valid       (i_br_valid),
    .i_br_taken       (i_br_taken),
    .i_br_mispred     (i_br_mispred),
    .i_clear          (i_clear),
    .i_freeze         (i_freeze),
    .wb               (wb),
    .o_branches       (o_branches),
    .o_branches_taken (o_branches_taken),
    .o_overflow       (o_overflow)
  );

  branch_stats #(.WIDTH(8)) dut8 (
    .clk              (clk),
    .rstn             (rstn),
    .i_br_valid       (v8),
    .i_br_taken       (1'b0),
    .i_br_mispred     (1'b0),
    .i_clear          (clr8),
    .i_freeze         (1'b0),
    .wb               (wb8),
    .o_branches       (o_branches8),
    .o_branches_taken (o_branches_taken8),
    .o_overflow       (o_overflow8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic v, input logic t, input logic m);
    i_br_valid   = v;
    i_br_taken   = t;
    i_br_mispred = m;
    tick();
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] dat);
    int unsigned n;
    n = 0;
    dat = '0;
    wb.i_wb_adr = adr;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    do begin
      tick();
      n++;
    end while (!wb.o_wb_ack && n < 8);
    if (!wb.o_wb_ack) check("rd_ack_timeout", {31'b0, wb.o_wb_ack}, 32'd1);
    else              dat = wb.o_wb_rdt;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
    int unsigned n;
    n = 0;
    wb.i_wb_adr = adr;
    wb.i_wb_dat = dat;
    wb.i_wb_we  = 1'b1;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    do begin
      tick();
      n++;
    end while (!wb.o_wb_ack && n < 8);
    if (!wb.o_wb_ack) check("wr_ack_timeout", {31'b0, wb.o_wb_ack}, 32'd1);
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rstn = 1'b0;
    i_br_valid = 1'b0; i_br_taken = 1'b0; i_br_mispred = 1'b0;
    i_clear = 1'b0; i_freeze = 1'b0;
    v8 = 1'b0; clr8 = 1'b0;
    wb.i_wb_adr = '0; wb.i_wb_dat = '0; wb.i_wb_we = 1'b0;
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
    wb8.i_wb_adr = '0; wb8.i_wb_dat = '0; wb8.i_wb_we = 1'b0;
    wb8.i_wb_cyc = 1'b0; wb8.i_wb_stb = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_branches", o_branches, 32'd0);
    check("rst_taken", o_branches_taken, 32'd0);
    check("rst_overflow", {31'b0, o_overflow}, 32'd0);
    check("rst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
    check("rst_rdt", wb.o_wb_rdt, 32'd0);
    rstn = 1'b1;

    // Ten events, taken alternating starting at 1
    for (int i = 0; i < 10; i++) ev(1'b1, (i % 2) == 0, 1'b0);
    check("alt_latency", o_branches, 32'd9);
    ev(1'b0, 1'b0, 1'b0);
    check("alt_branches", o_branches, 32'd10);
    check("alt_taken", o_branches_taken, 32'd5);
    wb_read(2'd0, rd); check("alt_rd_tot", rd, 32'd10);
    wb_read(2'd1, rd); check("alt_rd_tkn", rd, 32'd5);
    wb_read(2'd2, rd); check("alt_rd_mis", rd, 32'd0);
    check("rdt_idle", wb.o_wb_rdt, 32'd0);

    // Mispredict counting, qualifiers ignored without valid
    do_clear();
    ev(1'b1, 1'b0, 1'b1);
    ev(1'b0, 1'b1, 1'b1);
    ev(1'b1, 1'b1, 1'b1);
    ev(1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0);
    check("mix_branches", o_branches, 32'd3);
    wb_read(2'd1, rd); check("mix_rd_tkn", rd, 32'd1);
    wb_read(2'd2, rd); check("mix_rd_mis", rd, 32'd2);

    // Freeze after 4 events, then 6 more
    do_clear();
    for (int i = 0; i < 4; i++) ev(1'b1, 1'b0, 1'b0);
    i_freeze = 1'b1;
    for (int i = 0; i < 6; i++) ev(1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0);
    check("frz_branches", o_branches, 32'd4);
    wb_read(2'd0, rd); check("frz_rd_tot", rd, 32'd10);
    wb_read(2'd3, rd); check("frz_rd_ctl", rd, 32'h4);
    wb_write(2'd0, 32'h55);
    wb_read(2'd0, rd); check("ro_write_ignored", rd, 32'd10);
    i_freeze = 1'b0;
    tick();
    check("unfrz_branches", o_branches, 32'd10);

    // Clear and event in the same cycle at tot=7
    do_clear();
    for (int i = 0; i < 7; i++) ev(1'b1, 1'b1, 1'b0);
    i_clear = 1'b1;
    ev(1'b1, 1'b1, 1'b0);
    i_clear = 1'b0;
    check("clrev_branches", o_branches, 32'd0);
    ev(1'b1, 1'b1, 1'b0);
    ev(1'b0, 1'b0, 1'b0);
    wb_read(2'd0, rd); check("clrev_rd_tot", rd, 32'd0);
    wb_read(2'd3, rd); check("clrev_rd_ctl", rd, 32'h0);

    // Register freeze, then clear through the control register
    for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0);
    wb_write(2'd3, 32'h2);
    wb_read(2'd3, rd); check("ctl_frz_rd", rd, 32'h6);
    wb_write(2'd3, 32'h1);
    wb_read(2'd3, rd); check("ctl_clr_hold", rd, 32'h6);
    wb_read(2'd0, rd); check("ctl_clr_tot", rd, 32'd0);
    check("ctl_clr_branches", o_branches, 32'd0);
    wb_write(2'd3, 32'h0);
    tick();
    wb_read(2'd3, rd); check("ctl_unfrz_rd", rd, 32'h0);

    // Saturation on the 8-bit build
    for (int i = 0; i < 255; i++) begin v8 = 1'b1; tick(); end
    v8 = 1'b0;
    tick();
    check("sat_at_max", {24'b0, o_branches8}, 32'd255);
    check("sat_no_ovf_yet", {31'b0, o_overflow8}, 32'd0);
    v8 = 1'b1;
    tick();
    check("sat_ovf_set", {31'b0, o_overflow8}, 32'd1);
    tick();
    v8 = 1'b0;
    tick();
    check("sat_branches", {24'b0, o_branches8}, 32'd255);
    check("sat_ovf_sticky", {31'b0, o_overflow8}, 32'd1);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    check("sat_clr_ovf", {31'b0, o_overflow8}, 32'd0);
    check("sat_clr_branches", {24'b0, o_branches8}, 32'd0);

    // Reset in the middle of a bus access, from HOLD with nonzero counts
    do_clear();
    for (int i = 0; i < 5; i++) ev(1'b1, 1'b1, 1'b0);
    ev(1'b0, 1'b0, 1'b0);
    check("pre_rst_branches", o_branches, 32'd5);
    wb_write(2'd3, 32'h2);
    wb.i_wb_adr = 2'd0;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("arst_branches", o_branches, 32'd0);
    check("arst_taken", o_branches_taken, 32'd0);
    check("arst_overflow", {31'b0, o_overflow}, 32'd0);
    check("arst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
    check("arst_rdt", wb.o_wb_rdt, 32'd0);
    tick();
    check("arst_no_ack", {31'b0, wb.o_wb_ack}, 32'd0);
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    rstn = 1'b1;
    tick();
    wb_read(2'd3, rd); check("post_rst_ctl", rd, 32'h0);
    wb_read(2'd0, rd); check("post_rst_tot", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
